// File: rtl/data_mem_access_unit.sv
// Load/store unit: one core access at a time over a gnt/rvalid word-wide memory port,
// with byte-lane steering for stores and aligned, extended formatting for loads.
module data_mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        misalign_err,
  output logic [31:0] data_mem_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t             state, state_nxt;
  logic               we_q;
  logic [2:0]         funct3_q;
  logic [1:0]         off_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt;
  logic               accept, reject, capture, timeout;

  // Legal funct3 for the direction, and natural alignment of the access size.
  function automatic logic access_ok(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~a[0];
      3'b010:  ok = (a == 2'b00);
      3'b100:  ok = ~we;
      3'b101:  ok = ~we & ~a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'b0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'b0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  always_comb begin
    state_nxt    = state;
    stall        = 1'b0;
    done         = 1'b0;
    misalign_err = 1'b0;
    mem_req      = 1'b0;
    accept       = 1'b0;
    reject       = 1'b0;
    capture      = 1'b0;
    timeout      = 1'b0;
    case (state)
      IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          if (access_ok(req_we, req_funct3, req_addr[1:0])) begin
            accept    = 1'b1;
            state_nxt = REQ;
          end else begin
            reject    = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt) begin
          if (mem_rvalid) begin
            capture   = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        misalign_err = err_q;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b0;
      off_q       <= 2'b0;
      err_q       <= 1'b0;
      cnt         <= '0;
      data_mem_rd <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q      <= req_we;
        funct3_q  <= req_funct3;
        off_q     <= req_addr[1:0];
        err_q     <= 1'b0;
        mem_we    <= req_we;
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_wdata <= req_we ? store_lanes(req_funct3[1:0], req_wdata) : 32'b0;
        mem_be    <= req_we ? store_be(req_funct3[1:0], req_addr[1:0]) : 4'b1111;
      end
      if (reject) err_q <= 1'b1;
      // The wait counter is cleared while the request is outstanding so WAIT starts at 0.
      if (state == REQ)       cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CNT_W'(1);
      if (capture && !we_q) data_mem_rd <= load_fmt(funct3_q, off_q, mem_rdata);
      if (timeout) begin
        err_q       <= 1'b1;
        data_mem_rd <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit: directed scenarios plus randomized accesses
// compared against an arithmetic reference model of the load/store rules.
module tb_data_mem_access_unit;
  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic        misalign_err;
  logic [31:0] data_mem_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  data_mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .misalign_err(misalign_err), .data_mem_rd(data_mem_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_rd;

  int          obs_done_cyc, obs_done_cnt, obs_req_cyc, obs_stall_bad, obs_unstable;
  logic        obs_err, obs_we;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference rules, expressed on byte counts and shifts.
  function automatic bit m_legal(input bit we, input bit [2:0] f3, input bit [31:0] a);
    int nbytes;
    if (f3 == 3'd3 || f3 >= 3'd6) return 1'b0;
    if (we && f3 >= 3'd4) return 1'b0;
    nbytes = 1 << f3[1:0];
    return (int'(a[1:0]) % nbytes) == 0;
  endfunction

  function automatic logic [31:0] m_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] rd);
    int off;
    int v;
    off = int'(a[1:0]);
    if (f3[1:0] == 2'd0) begin
      v = int'((rd >> (8 * off)) & 32'hFF);
      if (!f3[2] && v >= 128) v = v - 256;
    end else if (f3[1:0] == 2'd1) begin
      v = int'((rd >> (8 * off)) & 32'hFFFF);
      if (!f3[2] && v >= 32768) v = v - 65536;
    end else begin
      v = int'(rd);
    end
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input bit [2:0] f3, input bit [31:0] d);
    if (f3[1:0] == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (f3[1:0] == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [3:0] m_be(input bit we, input bit [2:0] f3, input bit [31:0] a);
    int nbytes;
    if (!we) return 4'b1111;
    nbytes = 1 << f3[1:0];
    return 4'(((1 << nbytes) - 1) << int'(a[1:0]));
  endfunction

  // Drives one request and plays the memory side: gnt after gd REQ cycles,
  // rvalid rv cycles after gnt (rv<0: never). Records what the DUT showed.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int gd, input int rv);
    int k;
    int gnt_cyc;
    logic exp_stall;
    k = 0; gnt_cyc = -1;
    obs_done_cyc = -1; obs_done_cnt = 0; obs_req_cyc = 0; obs_stall_bad = 0; obs_unstable = 0;
    obs_err = 1'bx; obs_we = 1'bx; obs_addr = 'x; obs_wdata = 'x; obs_be = 'x;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      req_valid  = (obs_done_cyc < 0);
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      mem_rdata  = rd;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (mem_req) begin
        if (k == gd) begin
          mem_gnt = 1'b1;
          gnt_cyc = c;
          if (rv == 0) mem_rvalid = 1'b1;
        end
        k++;
      end else if (gnt_cyc >= 0 && rv > 0 && c == gnt_cyc + rv) begin
        mem_rvalid = 1'b1;
      end
      #1;
      if (mem_req) begin
        obs_req_cyc++;
        if (obs_req_cyc == 1) begin
          obs_addr = mem_addr; obs_we = mem_we; obs_wdata = mem_wdata; obs_be = mem_be;
        end else if (mem_addr !== obs_addr || mem_we !== obs_we ||
                     mem_wdata !== obs_wdata || mem_be !== obs_be) begin
          obs_unstable++;
        end
      end
      if (done === 1'b1) begin
        obs_done_cnt++;
        if (obs_done_cyc < 0) begin
          obs_done_cyc = c;
          obs_err      = misalign_err;
        end
      end
      exp_stall = (obs_done_cyc < 0);
      if (stall !== exp_stall) obs_stall_bad++;
      if (obs_done_cyc >= 0 && c == obs_done_cyc + 1) break;
    end
    req_valid  = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic check_access(input string tag, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int gd, input int rv);
    bit legal;
    int g;
    legal = m_legal(we, f3, addr);
    run_access(we, f3, addr, wd, rd, gd, rv);
    g = 1 + gd;
    if (!legal) begin
      chk({tag, "_done_cyc"}, obs_done_cyc, 1);
      chk({tag, "_err"}, obs_err, 1);
      chk({tag, "_req_cycles"}, obs_req_cyc, 0);
    end else begin
      chk({tag, "_req_cycles"}, obs_req_cyc, gd + 1);
      chk({tag, "_mem_addr"}, obs_addr, {addr[31:2], 2'b00});
      chk({tag, "_mem_we"}, obs_we, we);
      chk({tag, "_mem_be"}, obs_be, m_be(we, f3, addr));
      if (we) chk({tag, "_mem_wdata"}, obs_wdata, m_wdata(f3, wd));
      chk({tag, "_unstable"}, obs_unstable, 0);
      if (rv >= 0) begin
        chk({tag, "_done_cyc"}, obs_done_cyc, g + rv + 1);
        chk({tag, "_err"}, obs_err, 0);
        if (!we) exp_rd = m_load(f3, addr, rd);
      end else begin
        chk({tag, "_timeout_window"},
            (obs_done_cyc >= g + TIMEOUT && obs_done_cyc <= g + TIMEOUT + 2), 1);
        chk({tag, "_err"}, obs_err, 1);
        exp_rd = '0;
      end
    end
    chk({tag, "_done_pulses"}, obs_done_cnt, 1);
    chk({tag, "_stall_bad"}, obs_stall_bad, 0);
    chk({tag, "_data_mem_rd"}, data_mem_rd, exp_rd);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, misalign_err, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_be"}, mem_be, 0);
    chk({tag, "_data_mem_rd"}, data_mem_rd, 0);
  endtask

  initial begin
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    int          r_gd, r_rv;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    exp_rd = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    check_access("lb_imm",    1'b0, 3'b000, 32'h103, 32'h0,        32'h80000000, 0, 0);
    check_access("lbu_imm",   1'b0, 3'b100, 32'h103, 32'h0,        32'h80000000, 0, 0);
    check_access("sh_hi",     1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h55555555, 0, 0);
    check_access("lw_misal",  1'b0, 3'b010, 32'h106, 32'h0,        32'h0,        0, 0);
    check_access("lhu_slow",  1'b0, 3'b101, 32'h002, 32'h0,        32'hBEEF0000, 3, 2);
    check_access("lw_tmo",    1'b0, 3'b010, 32'h300, 32'h0,        32'h12345678, 0, -1);
    check_access("sb_off3",   1'b1, 3'b000, 32'h47,  32'hA5A5A5C3, 32'h0,        1, 1);
    check_access("lh_neg",    1'b0, 3'b001, 32'h40,  32'h0,        32'h0000F00D, 0, 1);
    check_access("sw",        1'b1, 3'b010, 32'h80,  32'hDEADBEEF, 32'h0,        2, 0);
    check_access("ill_011",   1'b0, 3'b011, 32'h0,   32'h0,        32'h0,        0, 0);
    check_access("ill_st100", 1'b1, 3'b100, 32'h0,   32'h0,        32'h0,        0, 0);
    check_access("sh_misal",  1'b1, 3'b001, 32'h5,   32'h0,        32'h0,        0, 0);

    // Reset in the middle of a load, then a late response.
    check_access("ld_pre", 1'b0, 3'b010, 32'h10, 32'h0, 32'h11223344, 0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    mem_gnt = mem_req;
    #1;
    chk("rst_mid_req", mem_req, 1);
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    chk("rst_mid_wait_stall", stall, 1);
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1;
    exp_rd = '0;
    chk_all_zero("rst_mid");
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("rst_mid_late_done", done, 0);
    chk("rst_mid_late_rd", data_mem_rd, exp_rd);
    check_access("post_rst", 1'b0, 3'b100, 32'h31, 32'h0, 32'h0000A700, 0, 0);

    for (int i = 0; i < 60; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = $urandom;
      r_gd   = int'($urandom_range(0, 3));
      r_rv   = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      check_access($sformatf("rnd%0d", i), r_we, r_f3, r_addr, $urandom, $urandom, r_gd, r_rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
